decode_stage: RTL and testbench

Registered instruction-decode pipeline stage between fetch and execute. Accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake. Splits the instruction into register addresses and function fields and produces one XLEN-wide immediate, chosen by opcode and sign-extended to XLEN. Holds decoded results in a two-entry skid buffer so that `in_ready` is driven from a register and backpressure never drops or reorders instructions.

---
 rtl/decode_pkg.sv | 75 +++++++
 rtl/decode_stage_imm_gen.sv | 34 +++
 rtl/decode_stage.sv | 183 ++++++++++++++++++
 tb/tb_decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, immediate-format enum, the decoded-entry
// struct stored in both skid-buffer slots, and small opcode lookup helpers.
// Buffer entries are sized for the widest datapath (64 bits); a 32-bit
// build uses only the low halves of pc and imm.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN_MAX-1:0] imm;
    imm_type_t           imm_type;
    logic                illegal;
  } decoded_t;

  // Immediate format selected by opcode; the *-32 forms exist only on RV64.
  function automatic imm_type_t imm_fmt(input logic [6:0] opc, input logic rv64);
    imm_type_t t;
    t = IMM_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC:                       t = IMM_U;
      OPC_JAL:                                  t = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_MISC_MEM, OPC_SYSTEM:                 t = IMM_I;
      OPC_BRANCH:                               t = IMM_B;
      OPC_STORE:                                t = IMM_S;
      OPC_OP_IMM_32:                            t = rv64 ? IMM_I : IMM_NONE;
      default:                                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  // True for any opcode in the format table, including the *-32 forms.
  function automatic logic opc_known(input logic [6:0] opc);
    logic k;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM, OPC_OP,
      OPC_OP_IMM_32, OPC_OP_32:                 k = 1'b1;
      default:                                  k = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator. Picks the format from the
// opcode, assembles the 32-bit immediate and sign-extends from instr[31]
// to XLEN (U included, so RV64 LUI/AUIPC get the upper word filled).
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type
);

  logic [31:0] imm32;

  // Format lookup and bit assembly; every format carries instr[31] as its sign
  always_comb begin
    imm_type = imm_fmt(instr[6:0], XLEN == 64);
    imm32    = '0;
    case (imm_type)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with a two-entry skid buffer.
// Decode happens combinationally on the input side; the outputs are driven
// only from the main entry register, and in_ready is a flop ("skid empty"),
// so there is no combinational path from either handshake input to outputs.
// Optional feature: define DECODE_ILLEGAL_EN to enable the illegal-
// instruction check; otherwise out_illegal is constant 0.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } buf_state_t;

  buf_state_t      state_q, state_d;
  decoded_t        main_q, skid_q, in_dec;
  logic [XLEN-1:0] gen_imm;
  imm_type_t       gen_type;
  logic            in_illegal;
  logic            accept, issue;
  logic            load_main_in, load_main_skid, load_skid_in;

  // ---------------------------------------------------------------- decode
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (in_instr),
    .imm      (gen_imm),
    .imm_type (gen_type)
  );

`ifdef DECODE_ILLEGAL_EN
  // Illegal check: bad length bits, unknown opcode, RV64-only opcode on
  // RV32, JALR with nonzero funct3, reserved branch funct3 (010/011)
  always_comb begin
    in_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11)                       in_illegal = 1'b1;
    if (!opc_known(in_instr[6:0]))                    in_illegal = 1'b1;
    if (XLEN == 32 && (in_instr[6:0] == OPC_OP_IMM_32 ||
                       in_instr[6:0] == OPC_OP_32))   in_illegal = 1'b1;
    if (in_instr[6:0] == OPC_JALR && in_instr[14:12] != 3'b000)
                                                      in_illegal = 1'b1;
    if (in_instr[6:0] == OPC_BRANCH &&
        (in_instr[14:12] == 3'b010 || in_instr[14:12] == 3'b011))
                                                      in_illegal = 1'b1;
  end
`else
  assign in_illegal = 1'b0;
`endif

  // Pack the incoming instruction into one buffer entry
  always_comb begin
    in_dec          = '0;
    in_dec.pc       = XLEN_MAX'(in_pc);
    in_dec.opcode   = in_instr[6:0];
    in_dec.funct3   = in_instr[14:12];
    in_dec.funct7   = in_instr[31:25];
    in_dec.rd       = in_instr[11:7];
    in_dec.rs1      = in_instr[19:15];
    in_dec.rs2      = in_instr[24:20];
    in_dec.imm      = XLEN_MAX'($signed(gen_imm));
    in_dec.imm_type = gen_type;
    in_dec.illegal  = in_illegal;
  end

  // ---------------------------------------------------------------- buffer
  assign accept = in_valid && in_ready;
  assign issue  = out_valid && out_ready;

  // Next state and entry-load controls; flush drops everything in flight
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && issue) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d      = S_TWO;
          load_skid_in = 1'b1;
        end else if (issue) begin
          state_d      = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only an issue can happen
        if (issue) begin
          state_d        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d        = S_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // State register; in_ready and out_valid are registered decodes of it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != S_TWO);
      out_valid <= (state_d != S_EMPTY);
    end
  end

  // Entry storage; reset clears both slots so nothing survives a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_dec;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= in_dec;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign out_pc       = main_q.pc[XLEN-1:0];
  assign out_opcode   = main_q.opcode;
  assign out_funct3   = main_q.funct3;
  assign out_funct7   = main_q.funct7;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_imm      = main_q.imm[XLEN-1:0];
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;

  generate
    if (XLEN < XLEN_MAX) begin : g_narrow
      // Upper halves of the 64-bit entry fields are not needed on RV32
      logic unused_hi;
      assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
    end
  endgenerate

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 and an RV64 instance share one stimulus
// stream. A queue of accepted (instr, pc) pairs models the buffer; expected
// fields come from a reference decoder built from the format rules.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [63:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
  } exp_t;

  logic [31:0] pc32, imm32;
  logic [63:0] pc64, imm64;
  obs_t o32, o64;
  ent_t q[$];
  int   errors = 0, checks = 0;
  bit   started = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o32.rdy),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(o32.vld), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(o32.opc), .out_funct3(o32.f3), .out_funct7(o32.f7),
    .out_rd(o32.rd), .out_rs1(o32.rs1), .out_rs2(o32.rs2), .out_imm(imm32),
    .out_imm_type(o32.ty), .out_illegal(o32.ill));

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o64.rdy),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(o64.vld), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(o64.opc), .out_funct3(o64.f3), .out_funct7(o64.f7),
    .out_rd(o64.rd), .out_rs1(o64.rs1), .out_rs2(o64.rs2), .out_imm(imm64),
    .out_imm_type(o64.ty), .out_illegal(o64.ill));

  assign o32.pc  = {32'b0, pc32};
  assign o32.imm = {32'b0, imm32};
  assign o64.pc  = pc64;
  assign o64.imm = imm64;

  // Reference decoder: immediate = sign fill above the field, OR'd fields
  function automatic exp_t ref_decode(input logic [31:0] i, input int xlen);
    exp_t e;
    logic [63:0] sgn, m;
    logic [6:0]  op;
    bit rv64, known, ill;
    op   = i[6:0];
    rv64 = (xlen == 64);
    sgn  = i[31] ? '1 : '0;
    m    = rv64 ? '1 : 64'hFFFF_FFFF;
    e.ty = 3'd0;
    case (op)
      7'h37, 7'h17:                      e.ty = 3'd4;
      7'h6F:                             e.ty = 3'd5;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: e.ty = 3'd1;
      7'h63:                             e.ty = 3'd3;
      7'h23:                             e.ty = 3'd2;
      7'h1B:                             e.ty = rv64 ? 3'd1 : 3'd0;
      default:                           e.ty = 3'd0;
    endcase
    case (e.ty)
      3'd1: e.imm = (sgn << 12) | 64'(i[31:20]);
      3'd2: e.imm = (sgn << 12) | (64'(i[31:25]) << 5) | 64'(i[11:7]);
      3'd3: e.imm = (sgn << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
      3'd4: e.imm = (sgn << 32) | (64'(i[31:12]) << 12);
      3'd5: e.imm = (sgn << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
      default: e.imm = 64'd0;
    endcase
    e.imm = e.imm & m;
    known = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                       7'h13, 7'h0F, 7'h73, 7'h33, 7'h1B, 7'h3B};
    ill = (i[1:0] != 2'b11) || !known || (!rv64 && op inside {7'h1B, 7'h3B}) ||
          (op == 7'h67 && i[14:12] != 3'd0) ||
          (op == 7'h63 && i[14:12] inside {3'd2, 3'd3});
    e.ill = ILL_EN && ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input int xlen);
    exp_t e;
    logic [63:0] m;
    m = (xlen == 64) ? '1 : 64'hFFFF_FFFF;
    chk({tag, ".in_ready"},  64'(o.rdy), 64'(q.size() < 2));
    chk({tag, ".out_valid"}, 64'(o.vld), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = ref_decode(q[0].instr, xlen);
      chk({tag, ".pc"},     o.pc,       q[0].pc & m);
      chk({tag, ".opcode"}, 64'(o.opc), 64'(q[0].instr[6:0]));
      chk({tag, ".funct3"}, 64'(o.f3),  64'(q[0].instr[14:12]));
      chk({tag, ".funct7"}, 64'(o.f7),  64'(q[0].instr[31:25]));
      chk({tag, ".rd"},     64'(o.rd),  64'(q[0].instr[11:7]));
      chk({tag, ".rs1"},    64'(o.rs1), 64'(q[0].instr[19:15]));
      chk({tag, ".rs2"},    64'(o.rs2), 64'(q[0].instr[24:20]));
      chk({tag, ".imm"},    o.imm,      e.imm);
      chk({tag, ".type"},   64'(o.ty),  64'(e.ty));
      chk({tag, ".illegal"},64'(o.ill), 64'(e.ill));
    end
  endtask

  // Model update on each edge from the pre-edge queue and inputs
  always @(posedge clk) begin
    bit acc, iss;
    if (rst) begin
      q.delete();
      started = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      iss = (q.size() > 0) && out_ready;
      if (iss) void'(q.pop_front());
      if (acc) q.push_back('{in_instr, in_pc});
    end
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      check_obs("rv32", o32, 32);
      check_obs("rv64", o64, 64);
    end
  end

  task automatic put(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  logic [6:0] opc_tab [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                               7'h13, 7'h0F, 7'h73, 7'h33, 7'h1B, 7'h3B};

  initial begin
    exp_t e;
    logic [31:0] ri;
    // Pin the reference decoder with hand-worked values
    e = ref_decode(32'hFFF00093, 32);
    chk("model.addi.imm", e.imm, 64'hFFFF_FFFF);
    e = ref_decode(32'hFE000EE3, 32);
    chk("model.beq.imm", e.imm, 64'hFFFF_FFFC);
    e = ref_decode(32'h800000B7, 64);
    chk("model.lui64.imm", e.imm, 64'hFFFF_FFFF_8000_0000);
    e = ref_decode(32'h00C0006F, 32);   // jal x0, +12
    chk("model.jal.imm", e.imm, 64'd12);

    // Reset with a valid input present: it must be ignored
    rst = 1; flush = 0; out_ready = 0;
    put(32'h00100093, 64'h40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", 64'(o32.vld), 64'd0);
    chk("reset.in_ready",  64'(o32.rdy), 64'd1);
    chk("reset.pc",        o32.pc, 64'd0);
    chk("reset.imm64",     o64.imm, 64'd0);
    chk("reset.type",      64'(o64.ty), 64'd0);
    chk("reset.illegal",   64'(o32.ill), 64'd0);
    chk("reset.opcode",    64'(o32.opc), 64'd0);
    rst = 0; in_valid = 0; out_ready = 1;

    // addi x1,x0,-1
    put(32'hFFF00093, 64'h1000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("addi.valid", 64'(o32.vld), 64'd1);
    chk("addi.imm",   o32.imm, 64'hFFFF_FFFF);
    chk("addi.type",  64'(o32.ty), 64'd1);
    chk("addi.rd",    64'(o32.rd), 64'd1);
    chk("addi.rs1",   64'(o32.rs1), 64'd0);
    // beq x0,x0,-4
    put(32'hFE000EE3, 64'h1004);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("beq.imm",  o32.imm, 64'hFFFF_FFFC);
    chk("beq.type", 64'(o32.ty), 64'd3);
    // lui x1,0x80000
    put(32'h800000B7, 64'h1008);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("lui64.imm",  o64.imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64.type", 64'(o64.ty), 64'd4);
    chk("lui32.imm",  o32.imm, 64'h8000_0000);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back with out_ready low for three cycles
    out_ready = 0;
    put(32'h00000013, 64'h100);
    @(posedge clk); #1 put(32'h00100113, 64'h104);
    @(negedge clk);
    chk("bp.in_ready_after_1st", 64'(o32.rdy), 64'd1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("bp.in_ready_after_2nd", 64'(o32.rdy), 64'd0);
    chk("bp.first_pc", o32.pc, 64'h100);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.second_pc",    o32.pc, 64'h104);
    chk("bp.second_valid", 64'(o32.vld), 64'd1);
    chk("bp.in_ready_back",64'(o32.rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp.drained", 64'(o32.vld), 64'd0);

    // Flush in TWO with an input present
    out_ready = 0;
    put(32'h00000013, 64'h200);
    @(posedge clk); #1 put(32'h00000013, 64'h204);
    @(posedge clk); #1 ;
    @(negedge clk);
    flush = 1; put(32'h00000013, 64'h208);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush2.out_valid", 64'(o32.vld), 64'd0);
    chk("flush2.in_ready",  64'(o32.rdy), 64'd1);
    // Flush in ONE while an input is accepted: the input must vanish
    out_ready = 1;
    put(32'h00000013, 64'h300);
    @(posedge clk); #1 ;
    @(negedge clk);
    flush = 1; put(32'h00000013, 64'h304);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("flush1.no_emit", 64'(o32.vld), 64'd0);

    // Illegal-instruction cases
    put(32'h00000000, 64'h400);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("ill.zero.rv32", 64'(o32.ill), 64'(ILL_EN));
    chk("ill.zero.rv64", 64'(o64.ill), 64'(ILL_EN));
    put(32'h0000003B, 64'h404);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("ill.op32.rv32", 64'(o32.ill), 64'(ILL_EN));
    chk("ill.op32.rv64", 64'(o64.ill), 64'd0);
    chk("ill.op32.type", 64'(o32.ty), 64'd0);
    @(posedge clk);

    // Reset while stalled in TWO
    @(negedge clk);
    out_ready = 0;
    put(32'h00000013, 64'h500);
    @(posedge clk); #1 put(32'h00000013, 64'h504);
    @(posedge clk); #1 in_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rststall.out_valid", 64'(o32.vld), 64'd0);
    chk("rststall.in_ready",  64'(o32.rdy), 64'd1);
    chk("rststall.pc",        o32.pc, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rststall.stay_empty", 64'(o64.vld), 64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ri = $urandom;
      if ($urandom_range(1, 0) == 1) ri[6:0] = opc_tab[$urandom_range(12, 0)];
      put(ri, {$urandom, $urandom});
      in_valid  = ($urandom_range(9, 0) < 7);
      out_ready = ($urandom_range(9, 0) < 6);
      flush     = ($urandom_range(31, 0) == 0);
      rst       = ($urandom_range(255, 0) == 0);
    end
    @(negedge clk);
    in_valid = 0; flush = 0; rst = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
